// File: rtl/t05_mem_pkg.sv
// Shared types and defaults for the t05 memory-bus arbiter.
package t05_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    // Owner encodings double as the one-hot value driven on grant.
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    localparam int DEF_MAX_STARVE = 4;
    localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/t05_mem_arbiter_if.sv
// Requester and memory-bus signal bundle for the t05 arbiter.
interface t05_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Requesters raise *_req and hold it with stable fields until the matching
    // one-cycle *_ack; the bus completes a strobe in any cycle bus_busy is low.
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              err;
    logic              bus_read;
    logic              bus_write;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_busy;
    logic [1:0]        grant;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, bus_rdata, bus_busy,
        output i_ack, i_rdata, d_ack, d_rdata, err,
        output bus_read, bus_write, bus_addr, bus_wdata, grant
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, bus_rdata, bus_busy,
        input  i_ack, i_rdata, d_ack, d_rdata, err,
        input  bus_read, bus_write, bus_addr, bus_wdata, grant
    );

endinterface

// File: rtl/t05_arb_pick.sv
// Data-first requester pick with a saturating fetch-starvation counter.
module t05_arb_pick
    import t05_mem_pkg::*;
#(
    parameter int MAX_STARVE = DEF_MAX_STARVE
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en_i,
    input  logic       i_req_i,
    input  logic       d_req_i,
    output logic [1:0] pick_o
);

    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;

    always_comb begin
        pick_o   = GRANT_NONE;
        starve_d = starve_q;
        if (d_req_i && !(i_req_i && starve_q == STARVE_MAX)) begin
            pick_o = GRANT_D;
        end else if (i_req_i) begin
            pick_o = GRANT_I;
        end
        // The counter only moves when the pick is actually turned into a grant.
        if (en_i) begin
            if (pick_o == GRANT_I) begin
                starve_d = '0;
            end else if (pick_o == GRANT_D) begin
                if (!i_req_i) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_MAX) begin
                    starve_d = starve_q + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/t05_mem_arbiter.sv
// Shared memory-bus arbiter: IDLE grants, ISSUE holds the strobe, ACK pulses the owner.
module t05_mem_arbiter
    import t05_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = DEF_MAX_STARVE,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               nrst,
    t05_mem_arbiter_if.slave   bus,
    output arb_state_t         state_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              bus_read_q, bus_read_d;
    logic              bus_write_q, bus_write_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic [DATA_W-1:0] rd_val;
    logic              pick_en;
    logic [1:0]        pick;

    t05_arb_pick #(.MAX_STARVE(MAX_STARVE)) u_pick (
        .clk     (clk),
        .nrst    (nrst),
        .en_i    (pick_en),
        .i_req_i (bus.i_req),
        .d_req_i (bus.d_req),
        .pick_o  (pick)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        bus_read_d  = bus_read_q;
        bus_write_d = bus_write_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = '0;
        d_rdata_d   = '0;
        err_d       = 1'b0;
        to_cnt_d    = to_cnt_q;
        pick_en     = 1'b0;
        rd_val      = (bus_read_q && !bus.bus_busy) ? bus.bus_rdata : '0;
        unique case (state_q)
            IDLE: begin
                pick_en = 1'b1;
                if (pick == GRANT_I) begin
                    grant_d     = GRANT_I;
                    bus_read_d  = 1'b1;
                    bus_write_d = 1'b0;
                    bus_addr_d  = bus.i_addr;
                    bus_wdata_d = '0;
                    to_cnt_d    = '0;
                    state_d     = ISSUE;
                end else if (pick == GRANT_D) begin
                    grant_d     = GRANT_D;
                    bus_read_d  = !bus.d_we;
                    bus_write_d = bus.d_we;
                    bus_addr_d  = bus.d_addr;
                    bus_wdata_d = bus.d_we ? bus.d_wdata : '0;
                    to_cnt_d    = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // A busy cycle that would reach TIMEOUT completes with err and no data.
                if (!bus.bus_busy || to_cnt_q == TO_LAST) begin
                    grant_d     = GRANT_NONE;
                    bus_read_d  = 1'b0;
                    bus_write_d = 1'b0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    err_d       = bus.bus_busy;
                    if (grant_q == GRANT_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = rd_val;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = rd_val;
                    end
                    state_d = ACK;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            grant_q     <= GRANT_NONE;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            bus_read_q  <= bus_read_d;
            bus_write_q <= bus_write_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.bus_read  = bus_read_q;
    assign bus.bus_write = bus_write_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    assign state_o       = state_q;

endmodule
